// File: rtl/stage_pkg.sv
// stage_pkg: shared state encoding and default parameters for the stage controller
package stage_pkg;
  typedef enum logic [2:0] {IDLE, ARM, PLAY, GAP, WIN, LOSE} state_e;
  localparam int NUM_ROUNDS_DEF = 4;
  localparam int LIVES_INIT_DEF = 3;
  localparam int TIMEOUT_CYC_DEF = 50_000_000;
endpackage

// File: rtl/stage_ctrl_if.sv
// stage_ctrl_if: player/minigame handshake and status bundle of the stage controller
interface stage_ctrl_if;
  logic start;
  logic mg_done;
  logic mg_enable;
  logic [2:0] round;
  logic [1:0] lives;
  logic busy;
  logic timeout;
  logic win;
  logic game_over;
  modport master (
    input start, mg_done,
    output mg_enable, round, lives, busy, timeout, win, game_over
  );
  modport slave (
    output start, mg_done,
    input mg_enable, round, lives, busy, timeout, win, game_over
  );
endinterface

// File: rtl/edge_detect.sv
// edge_detect: registered rising-edge detector; a level already high out of reset is not an edge
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev_q, rise_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      prev_q <= d;
      rise_q <= d & ~prev_q;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/stage_ctrl.sv
// stage_ctrl: round/lives/timeout sequencer driving a minigame through a registered enable
module stage_ctrl import stage_pkg::*; #(
  parameter int NUM_ROUNDS  = NUM_ROUNDS_DEF,
  parameter int LIVES_INIT  = LIVES_INIT_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic MCLK,
  input logic RESET,
  stage_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);
  localparam logic [1:0] LIVES0 = 2'(LIVES_INIT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] round_q, round_d;
  logic [1:0] lives_q, lives_d;
  logic timeout_q, timeout_d;
  logic mg_enable_q, mg_enable_d;
  logic busy_q, busy_d;
  logic win_q, win_d;
  logic game_over_q, game_over_d;
  logic start_rise, done_ok, expire;
  edge_detect u_edge (.clk(MCLK), .rst(RESET), .d(bus.start), .rise(start_rise));
  // timer==0 marks the first PLAY cycle, where a stale done is ignored
  assign done_ok = (state_q == PLAY) && (timer_q != '0) && bus.mg_done;
  assign expire = (state_q == PLAY) && (timer_q == TLAST) && !done_ok;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    round_d = round_q;
    lives_d = lives_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: if (start_rise) begin
        state_d = ARM;
        round_d = '0;
        lives_d = LIVES0;
        timer_d = '0;
      end
      ARM: begin
        state_d = PLAY;
        timer_d = '0;
      end
      PLAY: if (done_ok) begin
        timer_d = '0;
        state_d = round_q == LAST_ROUND ? WIN : GAP;
        round_d = round_q == LAST_ROUND ? round_q : round_q + 3'd1;
      end else if (expire) begin
        timeout_d = 1'b1;
        timer_d = '0;
        lives_d = lives_q == 2'd0 ? 2'd0 : lives_q - 2'd1;
        state_d = lives_d == 2'd0 ? LOSE : GAP;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      GAP: begin
        timer_d = timer_q == TW'(1) ? '0 : timer_q + 1'b1;
        state_d = timer_q == TW'(1) ? PLAY : GAP;
      end
      WIN, LOSE: if (start_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign mg_enable_d = state_d == PLAY;
  assign busy_d = state_d inside {ARM, PLAY, GAP};
  assign win_d = state_d == WIN;
  assign game_over_d = state_d == LOSE;
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q <= IDLE;
      timer_q <= '0;
      round_q <= '0;
      lives_q <= LIVES0;
      timeout_q <= 1'b0;
      mg_enable_q <= 1'b0;
      busy_q <= 1'b0;
      win_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      round_q <= round_d;
      lives_q <= lives_d;
      timeout_q <= timeout_d;
      mg_enable_q <= mg_enable_d;
      busy_q <= busy_d;
      win_q <= win_d;
      game_over_q <= game_over_d;
    end
  end
  assign bus.mg_enable = mg_enable_q;
  assign bus.round = round_q;
  assign bus.lives = lives_q;
  assign bus.busy = busy_q;
  assign bus.timeout = timeout_q;
  assign bus.win = win_q;
  assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_stage_ctrl.sv
// tb_stage_ctrl: directed and randomized checks of stage_ctrl against a phase/counter model
module tb_stage_ctrl;
  localparam int NR = 2;
  localparam int LI = 2;
  localparam int TO = 8;
  logic MCLK, RESET;
  stage_ctrl_if bus();
  stage_ctrl #(.NUM_ROUNDS(NR), .LIVES_INIT(LI), .TIMEOUT_CYC(TO)) dut (
    .MCLK(MCLK), .RESET(RESET), .bus(bus)
  );
  initial begin
    MCLK = 0;
    forever #5 MCLK = ~MCLK;
  end
  typedef enum {P_IDLE, P_ARM, P_PLAY, P_GAP, P_WIN, P_LOSE} phase_t;
  phase_t ph = P_IDLE;
  int m_round = 0, m_lives = LI, m_n = 0;
  bit m_tmo = 0, m_prev = 1, m_rise = 0, mvalid = 0;
  int n_pass = 0, n_tot = 0;
  int tgt = 99, mg_cnt = 0;
  bit rnd = 0;
  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic step(int n);
    repeat (n) @(negedge MCLK);
  endtask
  task automatic press();
    bus.start = 1;
    step(1);
    bus.start = 0;
    step(1);
  endtask
  task automatic model_step();
    bit rise;
    if (RESET) begin
      ph = P_IDLE; m_round = 0; m_lives = LI; m_n = 0; m_tmo = 0;
      m_prev = 1; m_rise = 0; mvalid = 1;
    end else begin
      rise = m_rise;
      m_rise = bus.start && !m_prev;
      m_prev = bus.start;
      m_tmo = 0;
      case (ph)
        P_IDLE: if (rise) begin ph = P_ARM; m_round = 0; m_lives = LI; end
        P_ARM: begin ph = P_PLAY; m_n = 0; end
        P_PLAY:
          if (m_n > 0 && bus.mg_done) begin
            if (m_round == NR - 1) ph = P_WIN;
            else begin m_round++; ph = P_GAP; m_n = 0; end
          end else if (m_n == TO - 1) begin
            m_tmo = 1; m_lives--; m_n = 0;
            ph = m_lives == 0 ? P_LOSE : P_GAP;
          end else m_n++;
        P_GAP: begin m_n++; if (m_n == 2) begin ph = P_PLAY; m_n = 0; end end
        default: if (rise) ph = P_IDLE;
      endcase
    end
  endtask
  initial forever begin
    @(posedge MCLK);
    model_step();
  end
  initial forever begin
    @(negedge MCLK);
    if (mvalid) begin
      chk("mg_enable", int'(bus.mg_enable), int'(ph == P_PLAY));
      chk("busy", int'(bus.busy), int'(ph == P_ARM || ph == P_PLAY || ph == P_GAP));
      chk("win", int'(bus.win), int'(ph == P_WIN));
      chk("game_over", int'(bus.game_over), int'(ph == P_LOSE));
      chk("timeout", int'(bus.timeout), int'(m_tmo));
      chk("round", int'(bus.round), m_round);
      chk("lives", int'(bus.lives), m_lives);
    end
  end
  // minigame stand-in: raises done tgt enabled cycles in, holds it until enable drops
  initial begin
    bus.mg_done = 0;
    forever begin
      @(negedge MCLK);
      if (bus.mg_enable !== 1'b1) begin
        bus.mg_done = 0;
        mg_cnt = 0;
        if (rnd) tgt = $urandom_range(0, 9);
      end else begin
        if (mg_cnt == tgt) bus.mg_done = 1;
        mg_cnt++;
      end
    end
  end
  initial begin
    RESET = 1;
    bus.start = 0;
    step(3);
    chk("rst_en", int'(bus.mg_enable), 0);
    chk("rst_lives", int'(bus.lives), 2);
    chk("rst_busy", int'(bus.busy), 0);
    RESET = 0;
    step(2);
    tgt = 2;
    press();
    chk("arm_busy", int'(bus.busy), 1);
    chk("arm_en", int'(bus.mg_enable), 0);
    step(1);
    chk("play_en", int'(bus.mg_enable), 1);
    chk("play_round", int'(bus.round), 0);
    chk("play_lives", int'(bus.lives), 2);
    step(3);
    chk("gap0_en", int'(bus.mg_enable), 0);
    chk("gap0_round", int'(bus.round), 1);
    step(1);
    chk("gap1_en", int'(bus.mg_enable), 0);
    step(1);
    chk("r1_en", int'(bus.mg_enable), 1);
    step(3);
    chk("win", int'(bus.win), 1);
    chk("win_busy", int'(bus.busy), 0);
    tgt = 99;
    press();
    chk("win_to_idle", int'(bus.win), 0);
    press();
    step(8);
    chk("pre_tmo", int'(bus.timeout), 0);
    step(1);
    chk("tmo1", int'(bus.timeout), 1);
    chk("tmo1_lives", int'(bus.lives), 1);
    chk("tmo1_round", int'(bus.round), 0);
    chk("tmo1_en", int'(bus.mg_enable), 0);
    step(1);
    chk("tmo1_pulse_end", int'(bus.timeout), 0);
    step(9);
    chk("tmo2", int'(bus.timeout), 1);
    chk("tmo2_lives", int'(bus.lives), 0);
    chk("lose", int'(bus.game_over), 1);
    press();
    chk("lose_to_idle", int'(bus.game_over), 0);
    press();
    tgt = 7;
    step(9);
    chk("late_done_round", int'(bus.round), 1);
    chk("late_done_lives", int'(bus.lives), 2);
    chk("late_done_tmo", int'(bus.timeout), 0);
    step(2);
    chk("r1_play", int'(bus.mg_enable), 1);
    RESET = 1;
    bus.start = 1;
    step(1);
    chk("midrst_en", int'(bus.mg_enable), 0);
    chk("midrst_round", int'(bus.round), 0);
    step(2);
    RESET = 0;
    step(4);
    chk("held_start_idle", int'(bus.busy), 0);
    bus.start = 0;
    step(2);
    press();
    chk("repress_arm", int'(bus.busy), 1);
    rnd = 1;
    repeat (4000) begin
      @(negedge MCLK);
      if ($urandom_range(0, 9) == 0) bus.start = !bus.start;
      RESET = $urandom_range(0, 199) == 0;
    end
    RESET = 0;
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
